// File: rtl/ula_multiciclo_if.sv
// rtl/ula_multiciclo_if.sv - start/busy/done operand and result bundle for ula_multiciclo
interface ula_multiciclo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       OP;
    logic [WIDTH-1:0] S;
    logic             Z;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             V;

    modport master (
        output start, A, B, OP,
        input  S, Z, HI, LO, busy, done, div_zero, V
    );

    modport slave (
        input  start, A, B, OP,
        output S, Z, HI, LO, busy, done, div_zero, V
    );
endinterface

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - registered multicycle ALU with iterative MULT/DIV into HI/LO
// Optional signed overflow flag on ADD/SUB: define ULA_OVERFLOW_DETECT_EN.
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic clock,
    input  logic reset,
    ula_multiciclo_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_DIV   = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_acc;
    logic [WIDTH-1:0] lo_acc;
    logic [WIDTH-1:0] mag_d;
    logic             is_div;
    logic             neg_main;
    logic             neg_rem;

    logic             pend;
    logic [3:0]       pend_op;
    logic [WIDTH-1:0] pend_a;
    logic [WIDTH-1:0] pend_b;

    logic [WIDTH-1:0] s_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             z_r;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;

    assign bus.S        = s_r;
    assign bus.Z        = z_r;
    assign bus.HI       = hi_r;
    assign bus.LO       = lo_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;

    // Request decode on the live inputs; only used on the accepting edge.
    logic             accept;
    logic             op_mul;
    logic             op_div;
    logic             op_signed;
    logic             b_zero;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign accept    = bus.start && !busy_r;
    assign op_mul    = (bus.OP == OP_MULT) || (bus.OP == OP_MULTU);
    assign op_div    = (bus.OP == OP_DIV)  || (bus.OP == OP_DIVU);
    assign op_signed = (bus.OP == OP_MULT) || (bus.OP == OP_DIV);
    assign b_zero    = (bus.B == '0);
    assign sa        = op_signed && bus.A[WIDTH-1];
    assign sb        = op_signed && bus.B[WIDTH-1];
    assign abs_a     = sa ? -bus.A : bus.A;
    assign abs_b     = sb ? -bus.B : bus.B;

    // One shift-add or restoring subtract-shift step per CALC cycle.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign mul_sum  = {1'b0, hi_acc} + {1'b0, (lo_acc[0] ? mag_d : {WIDTH{1'b0}})};
    assign div_sh   = {hi_acc, lo_acc[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, mag_d});
    assign div_diff = div_sh[WIDTH-1:0] - mag_d;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod     = {hi_acc, lo_acc};
    assign prod_fix = neg_main ? -prod : prod;
    assign fix_hi   = is_div ? (neg_rem ? -hi_acc : hi_acc) : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div ? (neg_main ? -lo_acc : lo_acc) : prod_fix[WIDTH-1:0];

    logic [WIDTH-1:0] alu_sum;
    logic [WIDTH-1:0] alu_diff;
    logic [WIDTH-1:0] alu_res;

    assign alu_sum  = pend_a + pend_b;
    assign alu_diff = pend_a - pend_b;

    always_comb begin
        alu_res = '0;
        case (pend_op)
            OP_AND:  alu_res = pend_a & pend_b;
            OP_OR:   alu_res = pend_a | pend_b;
            OP_ADD:  alu_res = alu_sum;
            OP_SUB:  alu_res = alu_diff;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(pend_a) < $signed(pend_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (pend_a < pend_b)};
            OP_NOR:  alu_res = ~(pend_a | pend_b);
            default: alu_res = '0;
        endcase
    end

`ifdef ULA_OVERFLOW_DETECT_EN
    logic v_r;
    logic ovf;

    assign bus.V = v_r;

    always_comb begin
        ovf = 1'b0;
        case (pend_op)
            OP_ADD:  ovf = (pend_a[WIDTH-1] == pend_b[WIDTH-1]) && (alu_sum[WIDTH-1] != pend_a[WIDTH-1]);
            OP_SUB:  ovf = (pend_a[WIDTH-1] != pend_b[WIDTH-1]) && (alu_diff[WIDTH-1] != pend_a[WIDTH-1]);
            default: ovf = 1'b0;
        endcase
    end
`else
    assign bus.V = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hi_acc   <= '0;
            lo_acc   <= '0;
            mag_d    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            pend     <= 1'b0;
            pend_op  <= '0;
            pend_a   <= '0;
            pend_b   <= '0;
            s_r      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            z_r      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
`ifdef ULA_OVERFLOW_DETECT_EN
            v_r      <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            pend   <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        dz_r <= 1'b0;
                        if ((op_mul || op_div) && !(op_div && b_zero)) begin
                            state    <= CALC;
                            busy_r   <= 1'b1;
                            cnt      <= '0;
                            is_div   <= op_div;
                            neg_main <= sa ^ sb;
                            neg_rem  <= sa;
                            hi_acc   <= '0;
                            lo_acc   <= op_div ? abs_a : abs_b;
                            mag_d    <= op_div ? abs_b : abs_a;
                        end else begin
                            // Simple ops and divide-by-zero retire one edge later without leaving IDLE.
                            pend    <= 1'b1;
                            pend_op <= bus.OP;
                            pend_a  <= bus.A;
                            pend_b  <= bus.B;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        hi_acc <= div_ge ? div_diff : div_sh[WIDTH-1:0];
                        lo_acc <= {lo_acc[WIDTH-2:0], div_ge};
                    end else begin
                        hi_acc <= mul_sum[WIDTH:1];
                        lo_acc <= {mul_sum[0], lo_acc[WIDTH-1:1]};
                    end
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi_r   <= fix_hi;
                    lo_r   <= fix_lo;
                    s_r    <= fix_lo;
                    z_r    <= (fix_lo == '0);
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
`ifdef ULA_OVERFLOW_DETECT_EN
                    v_r    <= 1'b0;
`endif
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase

            // Placed after the accept path so a retiring divide-by-zero flag wins over the clear.
            if (pend) begin
                done_r <= 1'b1;
                if ((pend_op == OP_DIV) || (pend_op == OP_DIVU)) begin
                    hi_r <= pend_a;
                    lo_r <= '1;
                    s_r  <= '1;
                    z_r  <= 1'b0;
                    dz_r <= 1'b1;
                end else begin
                    s_r <= alu_res;
                    z_r <= (alu_res == '0);
                end
`ifdef ULA_OVERFLOW_DETECT_EN
                v_r <= ovf;
`endif
            end
        end
    end
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - scoreboard bench for ula_multiciclo at WIDTH=32 and WIDTH=8
module tb_ula_multiciclo;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_UNDEF = 4'b0011;

`ifdef ULA_OVERFLOW_DETECT_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    typedef struct {
        logic [31:0] s;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        z;
        logic        dz;
        logic        v;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ula_multiciclo_if #(.WIDTH(32)) bus32();
    ula_multiciclo_if #(.WIDTH(8))  bus8();

    ula_multiciclo #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32.slave));
    ula_multiciclo #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8.slave));

    exp_t q32[$];
    exp_t q8[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit w8, input logic [31:0] s, input logic [31:0] hi,
                        input logic [31:0] lo, input logic dz, input logic v);
        exp_t e;
        e.s = s; e.hi = hi; e.lo = lo; e.z = (s == 32'h0); e.dz = dz; e.v = v;
        if (w8) q8.push_back(e);
        else    q32.push_back(e);
    endtask

    task automatic drive(input bit w8, input logic st, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.start = st; bus8.OP = op; bus8.A = a[7:0]; bus8.B = b[7:0];
        end else begin
            bus32.start = st; bus32.OP = op; bus32.A = a; bus32.B = b;
        end
    endtask

    function automatic logic get_done(input bit w8);
        return w8 ? bus8.done : bus32.done;
    endfunction

    function automatic logic get_busy(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction

    // chain=1 issues on the current done cycle instead of waiting for a fresh negedge.
    task automatic run(input bit w8, input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input int lat,
                       input bit poke, input bit chain);
        int cnt;
        if (!chain) @(negedge clock);
        drive(w8, 1'b1, op, a, b);
        @(posedge clock); #1;
        drive(w8, 1'b0, 4'b0, 32'h0, 32'h0);
        chk({name, "_busy_start"}, get_busy(w8), (lat > 1));
        cnt = 0;
        do begin
            @(posedge clock); #1;
            cnt++;
            if (poke && cnt == 5) drive(w8, 1'b1, OP_ADD, 32'h1, 32'h1);
            if (poke && cnt == 6) drive(w8, 1'b0, 4'b0, 32'h0, 32'h0);
        end while (!get_done(w8) && cnt < 200);
        chk({name, "_latency"}, cnt, lat);
        chk({name, "_busy_end"}, get_busy(w8), 1'b0);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (bus32.done) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", 1'b1, 1'b0);
            end else begin
                e = q32.pop_front();
                chk("S32",  bus32.S,        e.s);
                chk("Z32",  bus32.Z,        e.z);
                chk("HI32", bus32.HI,       e.hi);
                chk("LO32", bus32.LO,       e.lo);
                chk("DZ32", bus32.div_zero, e.dz);
                chk("V32",  bus32.V,        e.v);
            end
        end
        if (bus8.done) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 1'b1, 1'b0);
            end else begin
                e = q8.pop_front();
                chk("S8",  bus8.S,        e.s);
                chk("Z8",  bus8.Z,        e.z);
                chk("HI8", bus8.HI,       e.hi);
                chk("LO8", bus8.LO,       e.lo);
                chk("DZ8", bus8.div_zero, e.dz);
                chk("V8",  bus8.V,        e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 4'b0, 32'h0, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_S",    bus32.S,        32'h0);
        chk("rst_Z",    bus32.Z,        1'b0);
        chk("rst_HI",   bus32.HI,       32'h0);
        chk("rst_LO",   bus32.LO,       32'h0);
        chk("rst_busy", bus32.busy,     1'b0);
        chk("rst_done", bus32.done,     1'b0);
        chk("rst_dz",   bus32.div_zero, 1'b0);
        chk("rst_V",    bus32.V,        1'b0);
        @(negedge clock);
        reset = 1'b0;

        push(0, 32'h80000000, 32'h0, 32'h0, 1'b0, OVF);
        run(0, "add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 1, 0, 0);
        push(0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        run(0, "sub_zero", OP_SUB, 32'd5, 32'd5, 1, 0, 0);
        push(0, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0);
        run(0, "slt", OP_SLT, 32'hFFFFFFFF, 32'h1, 1, 0, 0);
        push(0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        run(0, "sltu", OP_SLTU, 32'hFFFFFFFF, 32'h1, 1, 0, 0);
        push(0, 32'hF000F000, 32'h0, 32'h0, 1'b0, 1'b0);
        run(0, "and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1, 0, 0);
        push(0, 32'hFFF0FFF0, 32'h0, 32'h0, 1'b0, 1'b0);
        run(0, "or", OP_OR, 32'hF0F0F0F0, 32'hFF00FF00, 1, 0, 0);
        push(0, 32'h000F000F, 32'h0, 32'h0, 1'b0, 1'b0);
        run(0, "nor", OP_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 1, 0, 0);

        push(0, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        run(0, "mult", OP_MULT, 32'hFFFFFFFD, 32'd7, 33, 1, 0);
        push(0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run(0, "div", OP_DIV, 32'hFFFFFFF9, 32'd2, 33, 0, 0);
        push(0, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFFF, 1'b1, 1'b0);
        run(0, "divu_zero", OP_DIVU, 32'd100, 32'd0, 1, 0, 0);
        push(0, 32'h0, 32'd100, 32'hFFFFFFFF, 1'b0, 1'b0);
        run(0, "undef", OP_UNDEF, 32'h12345678, 32'h9ABCDEF0, 1, 0, 0);

        @(negedge clock);
        drive(0, 1'b1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(posedge clock); #1;
        drive(0, 1'b0, 4'b0, 32'h0, 32'h0);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_S",    bus32.S,        32'h0);
        chk("abort_Z",    bus32.Z,        1'b0);
        chk("abort_HI",   bus32.HI,       32'h0);
        chk("abort_LO",   bus32.LO,       32'h0);
        chk("abort_busy", bus32.busy,     1'b0);
        chk("abort_done", bus32.done,     1'b0);
        chk("abort_dz",   bus32.div_zero, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        push(0, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0);
        run(0, "add_after_abort", OP_ADD, 32'd3, 32'd4, 1, 0, 0);

        push(1, 32'hEB, 32'hFF, 32'hEB, 1'b0, 1'b0);
        run(1, "mult8", OP_MULT, 32'hFD, 32'h07, 9, 0, 0);
        push(1, 32'h80, 32'h00, 32'h80, 1'b0, 1'b0);
        run(1, "div8_minneg", OP_DIV, 32'h80, 32'hFF, 9, 0, 0);
        push(1, 32'h80, 32'h00, 32'h80, 1'b0, OVF);
        run(1, "add8_chained", OP_ADD, 32'h7F, 32'h01, 1, 0, 1);

        repeat (3) @(posedge clock);
        #1;
        chk("q32_empty", q32.size(), 0);
        chk("q8_empty",  q8.size(),  0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
